vga_scan_arbiter: RTL and testbench

VGA_SCAN_ARBITER -- requirements
Module: vga_scan_arbiter

---
 rtl/vga_scan_arbiter_if.sv | 27 ++
 rtl/vga_scan_arbiter.sv | 138 +++++++++++++
 tb/tb_vga_scan_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_arbiter_if
// Brief    : Capture-writer request/grant handshake for the shared sample RAM.
// Revision : 1.0
// ============================================================================
interface vga_scan_arbiter_if;
  logic cap_req;
  logic cap_done;
  logic cap_grant;
  logic cap_abort;

  modport master (
    output cap_req,
    output cap_done,
    input  cap_grant,
    input  cap_abort
  );

  modport slave (
    input  cap_req,
    input  cap_done,
    output cap_grant,
    output cap_abort
  );
endinterface
`default_nettype wire

// File: rtl/vga_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_arbiter
// Brief    : VGA scan timing plus vblank arbitration of the sample RAM between
//            the display reader and a capture writer. SCOPE_FREEZE_EN adds a
//            freeze input that inhibits new grants.
// Revision : 1.0
// ============================================================================
module vga_scan_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic              clk_25MHz,
  input  logic              reset,
  input  logic              run,
`ifdef SCOPE_FREEZE_EN
  input  logic              freeze,
`endif
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [9:0]        pixel_x,
  output logic [9:0]        pixel_y,
  output logic              frame_start,
  output logic              rd_en,
  vga_scan_arbiter_if.slave cap
);

  localparam logic [9:0] c_H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] c_H_RD_LAST = 10'(H_ACTIVE - 2);
  localparam logic [9:0] c_HS_BEG    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] c_VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] c_V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_V_GNT_END = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    REVOKE = 2'd2
  } state_t;

  logic [9:0] r_h;
  logic [9:0] r_v;
  state_t     r_state;
  logic       r_grant;
  logic       r_abort;

  logic [9:0] w_v_next;
  logic       w_live;
  logic       w_gnt_window;
  logic       w_revoke_pt;
  logic       w_freeze;

`ifdef SCOPE_FREEZE_EN
  assign w_freeze = freeze;
`else
  assign w_freeze = 1'b0;
`endif

  assign w_v_next     = (r_v == c_V_LAST) ? 10'd0 : r_v + 10'd1;
  assign w_live       = run & ~reset;
  assign w_gnt_window = (r_v >= c_V_ACT) && (r_v <= c_V_GNT_END);
  assign w_revoke_pt  = (r_h == 10'd0) && (r_v == c_V_LAST);

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_h <= 10'd0;
      r_v <= 10'd0;
    end else if (run) begin
      if (r_h == c_H_LAST) begin
        r_h <= 10'd0;
        r_v <= w_v_next;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // A release arriving at the revoke point wins, so no abort is raised.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cap.cap_req && w_gnt_window && !w_freeze) begin
            r_state <= GRANT;
            r_grant <= 1'b1;
          end
        end
        GRANT: begin
          if (cap.cap_done) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
          end else if (w_revoke_pt) begin
            r_state <= REVOKE;
            r_grant <= 1'b0;
            r_abort <= 1'b1;
          end
        end
        REVOKE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 1'b0;
        end
      endcase
    end
  end

  assign hsync         = !((r_h >= c_HS_BEG) && (r_h <= c_HS_END));
  assign vsync         = !((r_v >= c_VS_BEG) && (r_v <= c_VS_END));
  assign video_on      = w_live && (r_h < c_H_ACT) && (r_v < c_V_ACT);
  // Read strobe leads the pixel by one cycle, including the wrap into line 0.
  assign rd_en         = w_live && (((r_h <= c_H_RD_LAST) && (r_v < c_V_ACT)) ||
                                    ((r_h == c_H_LAST) && (w_v_next < c_V_ACT)));
  assign frame_start   = w_live && (r_h == 10'd0) && (r_v == 10'd0);
  assign pixel_x       = r_h;
  assign pixel_y       = r_v;
  assign cap.cap_grant = r_grant;
  assign cap.cap_abort = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_arbiter
// Brief    : Randomised scoreboard bench for vga_scan_arbiter on reduced timing.
// Revision : 1.0
// ============================================================================
module tb_vga_scan_arbiter;

  localparam int HA = 20, HF = 2, HS = 4, HB = 4;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk_25MHz = 1'b0;
  logic reset;
  logic run;
  logic frz;
  logic hsync, vsync, video_on, frame_start, rd_en;
  logic [9:0] pixel_x, pixel_y;

  vga_scan_arbiter_if bus ();

  vga_scan_arbiter #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk_25MHz   (clk_25MHz),
    .reset       (reset),
    .run         (run),
`ifdef SCOPE_FREEZE_EN
    .freeze      (frz),
`endif
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_start (frame_start),
    .rd_en       (rd_en),
    .cap         (bus)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  typedef struct {
    int         cyc;
    logic       hs, vs, von, rd, fs, g, ab;
    logic [9:0] x, y;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference state: linear scan position and capture ownership.
  int   m_pos   = 0;
  bit   m_grant = 1'b0;
  bit   m_abort = 1'b0;

  function automatic bit active(input int pos);
    return ((pos % HT) < HA) && ((pos / HT) < VA);
  endfunction

  function automatic void chk(input string nm, input logic [9:0] act,
                              input logic [9:0] exp, input int c);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, c, act, exp);
    end
  endfunction

  task automatic step(input bit rn, input bit rq, input bit dn, input bit rs, input bit fz);
    exp_t e;
    int   h, v;
    bit   live, ng, na, fz_eff;
    run = rn; bus.cap_req = rq; bus.cap_done = dn; reset = rs; frz = fz;
`ifdef SCOPE_FREEZE_EN
    fz_eff = fz;
`else
    fz_eff = 1'b0;
`endif
    h    = m_pos % HT;
    v    = m_pos / HT;
    live = rn && !rs;
    e.cyc = cyc;
    e.hs  = !(h >= HA + HF && h < HA + HF + HS);
    e.vs  = !(v >= VA + VF && v < VA + VF + VS);
    e.von = live && active(m_pos);
    e.rd  = live && active((m_pos + 1) % FRAME);
    e.fs  = live && (m_pos == 0);
    e.x   = 10'(h);
    e.y   = 10'(v);
    e.g   = m_grant;
    e.ab  = m_abort;
    q.push_back(e);
    if (rs) begin
      m_pos = 0; m_grant = 1'b0; m_abort = 1'b0;
    end else begin
      ng = m_grant;
      na = 1'b0;
      if (m_abort)
        ng = 1'b0;
      else if (!m_grant)
        ng = rq && (v >= VA) && (v <= VT - 2) && !fz_eff;
      else if (dn)
        ng = 1'b0;
      else if (h == 0 && v == VT - 1) begin
        ng = 1'b0; na = 1'b1;
      end
      m_grant = ng;
      m_abort = na;
      if (rn) m_pos = (m_pos + 1) % FRAME;
    end
    cyc++;
    @(posedge clk_25MHz);
    #1;
  endtask

  always @(negedge clk_25MHz) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk("hsync",       10'(hsync),         10'(m_e.hs),  m_e.cyc);
      chk("vsync",       10'(vsync),         10'(m_e.vs),  m_e.cyc);
      chk("video_on",    10'(video_on),      10'(m_e.von), m_e.cyc);
      chk("rd_en",       10'(rd_en),         10'(m_e.rd),  m_e.cyc);
      chk("frame_start", 10'(frame_start),   10'(m_e.fs),  m_e.cyc);
      chk("pixel_x",     pixel_x,            m_e.x,        m_e.cyc);
      chk("pixel_y",     pixel_y,            m_e.y,        m_e.cyc);
      chk("cap_grant",   10'(bus.cap_grant), 10'(m_e.g),   m_e.cyc);
      chk("cap_abort",   10'(bus.cap_abort), 10'(m_e.ab),  m_e.cyc);
      chk("grant_rd_excl", 10'(bus.cap_grant && rd_en), 10'd0, m_e.cyc);
    end
  end

  initial begin
    int lim;
    reset = 1'b1; run = 1'b0; frz = 1'b0;
    bus.cap_req = 1'b0; bus.cap_done = 1'b0;
    @(posedge clk_25MHz);
    #1;
    // held reset with run high: gated outputs must stay low
    repeat (3) step(1, 0, 0, 1, 0);
    repeat (2 * FRAME) step(1, 0, 0, 0, 0);
    // request never released: forced revoke each frame
    repeat (2 * FRAME) step(1, 1, 0, 0, 0);
    // random request with occasional release
    repeat (3 * FRAME)
      step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0, 0, 0);
    // release coinciding with the revoke point
    repeat (2 * FRAME)
      step(1, 1, m_grant && (m_pos == (VT - 1) * HT), 0, 0);
    // run low for 100 cycles inside the active area
    lim = 0;
    while (m_pos != 5 * HT + 7 && lim < 2 * FRAME) begin
      step(1, 0, 0, 0, 0);
      lim++;
    end
    repeat (100) step(0, 0, 0, 0, 0);
    repeat (3 * HT) step(1, 0, 0, 0, 0);
    // reset while the writer holds the grant
    lim = 0;
    while (!m_grant && lim < 2 * FRAME) begin
      step(1, 1, 0, 0, 0);
      lim++;
    end
    chk("grant_reached", 10'(m_grant), 10'd1, cyc);
    step(1, 1, 0, 1, 0);
    repeat (HT) step(1, 0, 0, 0, 0);
    // everything random, including run, reset and freeze
    repeat (10 * FRAME)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0);
    @(negedge clk_25MHz);
    #1;
    chk("queue_drained", 10'(q.size()), 10'd0, cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
